// File: rtl/arquitetura_nios2_qsys_0_oci_dct_packer.sv
// OCI data-trace compression packer: packs 2-bit symbol fragments LSB-first into 30-bit words.
// Optional idle-timeout flush of partial words is built when OCI_DCT_TIMEOUT_EN is defined.
module arquitetura_nios2_qsys_0_oci_dct_packer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frag_valid,
  output logic        frag_ready,
  input  logic [7:0]  frag_data,
  input  logic [2:0]  frag_len,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  input  logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {RUN, FLUSH, ENDED} state_t;

  state_t      state, state_nxt;
  logic [29:0] acc, acc_nxt;
  logic [3:0]  acc_cnt, acc_cnt_nxt;
  logic [2:0]  len;
  logic [4:0]  sum;
  logic [7:0]  frag_mask;
  logic [29:0] frag_bits;
  logic        out_free, accept, overflow, push, timeout_hit;

  // Lengths above 4 saturate; symbols beyond the length are masked off.
  assign len = (frag_len > 3'd4) ? 3'd4 : frag_len;

  always_comb begin
    case (len)
      3'd0:    frag_mask = 8'h00;
      3'd1:    frag_mask = 8'h03;
      3'd2:    frag_mask = 8'h0F;
      3'd3:    frag_mask = 8'h3F;
      default: frag_mask = 8'hFF;
    endcase
  end

  assign frag_bits  = {22'b0, frag_data & frag_mask};
  assign sum        = {1'b0, acc_cnt} + {2'b0, len};
  assign out_free   = !dct_valid || dct_ready;
  assign frag_ready = (state == RUN) && (out_free || acc_cnt <= 4'd11);
  assign accept     = frag_valid && frag_ready;
  // Overflow needs acc_cnt >= 12, which frag_ready only allows when out_free.
  assign overflow   = accept && (sum > 5'd15);
  assign push       = out_free && (acc_cnt != 4'd0) &&
                      (overflow || acc_cnt == 4'd15 || state == FLUSH || timeout_hit);

  assign test_has_ended = (state == ENDED);

`ifdef OCI_DCT_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);
  logic [TIMEOUT_W-1:0] idle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (accept || push || state != RUN || acc_cnt == 4'd0)
      idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT_MAX)
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = (state == RUN) && !accept && (idle_cnt == TIMEOUT_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_nxt     = acc;
    acc_cnt_nxt = acc_cnt;
    if (push) begin
      acc_nxt     = '0;
      acc_cnt_nxt = '0;
      if (accept) begin
        acc_nxt     = frag_bits;
        acc_cnt_nxt = {1'b0, len};
      end
    end else if (accept) begin
      acc_nxt     = acc | (frag_bits << {acc_cnt, 1'b0});
      acc_cnt_nxt = sum[3:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (test_ending) state_nxt = FLUSH;
      FLUSH:   if (acc_cnt == 4'd0 && !dct_valid) state_nxt = ENDED;
      ENDED:   state_nxt = ENDED;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      acc     <= '0;
      acc_cnt <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      acc_cnt <= acc_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (push) begin
      dct_valid  <= 1'b1;
      dct_buffer <= acc;
      dct_count  <= acc_cnt;
    end else if (dct_ready) begin
      dct_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arquitetura_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI DCT packer: directed table, corner sequences,
// and a random run scored against a symbol-queue model.
module tb_arquitetura_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frag_valid = 1'b0;
  logic        frag_ready;
  logic [7:0]  frag_data = '0;
  logic [2:0]  frag_len = '0;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending = 1'b0;
  logic        test_has_ended;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arquitetura_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk), .reset(reset),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_data(frag_data), .frag_len(frag_len),
    .dct_valid(dct_valid), .dct_ready(dct_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frag_valid = 1'b0;
    test_ending = 1'b0;
    dct_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_frag(input logic [7:0] data, input logic [2:0] len, input string name);
    @(negedge clk);
    frag_valid = 1'b1;
    frag_data  = data;
    frag_len   = len;
    #1 check(name, frag_ready, 1);
    @(posedge clk);
    #1 frag_valid = 1'b0;
  endtask

  // Directed vectors; outputs are checked just after the edge that consumes the row.
  typedef struct {
    logic        fv;
    logic [7:0]  data;
    logic [2:0]  len;
    logic        exp_ready;
    logic        exp_valid;
    logic [3:0]  exp_count;
    logic [29:0] exp_buf;
  } vec_t;

  vec_t vecs[16];

  // Reference model: pending symbols of the open word and the expected word stream.
  typedef struct {
    logic [3:0]  count;
    logic [29:0] buffer;
  } word_t;

  logic [1:0] syms[$];
  word_t      exp_q[$];

  function automatic void close_word();
    word_t w;
    if (syms.size() == 0) return;
    w.count  = 4'(syms.size());
    w.buffer = '0;
    for (int k = 0; k < syms.size(); k++)
      w.buffer = w.buffer | (30'(syms[k]) << (2 * k));
    exp_q.push_back(w);
    syms.delete();
  endfunction

  function automatic void add_frag(input logic [7:0] data, input logic [2:0] len);
    int l;
    l = (len > 3'd4) ? 4 : int'(len);
    if (l == 0) return;
    if (syms.size() + l > 15) close_word();
    for (int j = 0; j < l; j++)
      syms.push_back(2'((data >> (2 * j)) & 8'h3));
    if (syms.size() == 15) close_word();
  endfunction

  task automatic score_cycle(input string tag);
    word_t w;
    if (dct_valid) check({tag, "_count_nonzero"}, (dct_count != 4'd0), 1);
    if (dct_valid && dct_ready) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_word"}, exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        check({tag, "_word_count"}, dct_count, w.count);
        check({tag, "_word_buffer"}, dct_buffer, w.buffer);
      end
    end
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0]  = '{1'b1, 8'hE4, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[1]  = '{1'b1, 8'hE4, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[2]  = '{1'b1, 8'hE4, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[3]  = '{1'b1, 8'hE4, 3'd4, 1'b1, 1'b1, 4'd12, 30'h00E4E4E4};
    vecs[4]  = '{1'b1, 8'hFF, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[5]  = '{1'b1, 8'hFF, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[6]  = '{1'b1, 8'hFF, 3'd3, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[7]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 4'd15, 30'h3FFFFFE4};
    vecs[8]  = '{1'b1, 8'hFF, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[9]  = '{1'b1, 8'hFF, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[10] = '{1'b1, 8'hFF, 3'd4, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[11] = '{1'b1, 8'hFF, 3'd3, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[12] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 4'd15, 30'h3FFFFFFF};
    vecs[13] = '{1'b1, 8'h1B, 3'd7, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[14] = '{1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 4'd0,  30'h0};
    vecs[15] = '{1'b1, 8'h02, 3'd1, 1'b1, 1'b0, 4'd0,  30'h0};

    // Reset state
    do_reset();
    #1;
    check("rst_valid", dct_valid, 0);
    check("rst_count", dct_count, 0);
    check("rst_buffer", dct_buffer, 0);
    check("rst_ended", test_has_ended, 0);
    check("rst_ready", frag_ready, 1);

    // Table: packing, exact fill, length saturation and len-0 no-op
    dct_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      frag_valid = vecs[i].fv;
      frag_data  = vecs[i].data;
      frag_len   = vecs[i].len;
      #1 check($sformatf("vec%0d_ready", i), frag_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1 check($sformatf("vec%0d_valid", i), dct_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_count", i), dct_count, vecs[i].exp_count);
        check($sformatf("vec%0d_buffer", i), dct_buffer, vecs[i].exp_buf);
      end
    end
    @(negedge clk);
    frag_valid = 1'b0;

    // Drain: 5 slots (0x21B) pending, test_ending pulse
    test_ending = 1'b1;
    @(posedge clk);
    #1 test_ending = 1'b0;
    check("flush_ready", frag_ready, 0);
    check("flush_valid_early", dct_valid, 0);
    @(posedge clk);
    #1;
    check("drain_valid", dct_valid, 1);
    check("drain_count", dct_count, 5);
    check("drain_buffer", dct_buffer, 30'h21B);
    check("drain_upper_zero", dct_buffer[29:10], 0);
    dct_ready = 1'b0;
    @(posedge clk);
    #1;
    check("drain_hold_valid", dct_valid, 1);
    check("drain_hold_buffer", dct_buffer, 30'h21B);
    check("drain_not_ended", test_has_ended, 0);
    dct_ready = 1'b1;
    n = 0;
    while (!test_has_ended && n < 6) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_ended", test_has_ended, 1);
    frag_valid  = 1'b1;
    frag_data   = 8'hAA;
    frag_len    = 3'd2;
    test_ending = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("ended_ready", frag_ready, 0);
      check("ended_valid", dct_valid, 0);
      check("ended_sticky", test_has_ended, 1);
    end
    frag_valid  = 1'b0;
    test_ending = 1'b0;

    // Backpressure: word pending with acc at 12 slots
    do_reset();
    dct_ready = 1'b0;
    repeat (4) send_frag(8'hE4, 3'd4, "bp_fill_ready");
    send_frag(8'h1B, 3'd4, "bp_fill_ready");
    send_frag(8'h1B, 3'd4, "bp_fill_ready");
    @(negedge clk);
    frag_valid = 1'b1;
    frag_data  = 8'h55;
    frag_len   = 3'd4;
    #1;
    check("bp_ready_low", frag_ready, 0);
    check("bp_count", dct_count, 12);
    check("bp_buffer", dct_buffer, 30'h00E4E4E4);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", dct_valid, 1);
      check("bp_hold_buffer", dct_buffer, 30'h00E4E4E4);
    end
    dct_ready = 1'b1;
    #1 check("bp_ready_release", frag_ready, 1);
    @(posedge clk);
    #1;
    frag_valid = 1'b0;
    dct_ready  = 1'b0;
    check("bp_next_valid", dct_valid, 1);
    check("bp_next_count", dct_count, 12);
    check("bp_next_buffer", dct_buffer, 30'h001B1BE4);

    // Async reset mid-cycle while a word is pending
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", dct_valid, 0);
    check("areset_count", dct_count, 0);
    check("areset_ended", test_has_ended, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("areset_ready", frag_ready, 1);
    check("areset_no_word", dct_valid, 0);

    // Random stream against the symbol-queue model
    syms.delete();
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      frag_valid = ($urandom_range(0, 3) != 0);
      frag_data  = 8'($urandom);
      frag_len   = 3'($urandom_range(0, 7));
      dct_ready  = ($urandom_range(0, 9) < 7);
      #1;
      score_cycle("rnd");
      if (frag_valid && frag_ready) add_frag(frag_data, frag_len);
    end
    @(negedge clk);
    frag_valid  = 1'b0;
    test_ending = 1'b1;
    close_word();
    n = 0;
    while (!test_has_ended && n < 300) begin
      dct_ready = ($urandom_range(0, 1) == 1);
      #1 score_cycle("rnd_drain");
      @(negedge clk);
      test_ending = 1'b0;
      n++;
    end
    check("rnd_ended", test_has_ended, 1);
    check("rnd_words_left", exp_q.size(), 0);

    // Idle timeout on a partial word
    do_reset();
    dct_ready = 1'b1;
    send_frag(8'h0E, 3'd2, "to_ready");
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 n++;
      if (dct_valid) begin
        seen = 1'b1;
        break;
      end
    end
`ifdef OCI_DCT_TIMEOUT_EN
    check("to_seen", seen, 1);
    check("to_count", dct_count, 2);
    check("to_buffer", dct_buffer, 30'hE);
    check("to_latency", (n >= 64 && n <= 66), 1);
`else
    check("no_timeout_push", seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
